// File: rtl/ps2_tx.sv
// Host-to-device PS/2 command transmitter (request-to-send, start, 8 data, odd parity, stop, ack).
// Define PS2_ACK_CHECK_EN to sample the device acknowledge into ack_err; otherwise ack_err is tied to 0.
module ps2_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    inout  wire        ps2c,
    inout  wire        ps2d,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       ack_err
);

    localparam int CW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(INHIBIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RTS   = 3'd1,
        S_START = 3'd2,
        S_DATA  = 3'd3,
        S_STOP  = 3'd4,
        S_ACK   = 3'd5
    } state_t;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    state_t                r_state, w_state_next;
    logic [8:0]            r_b, w_b_next;
    logic [3:0]            r_n, w_n_next;
    logic [CW-1:0]         r_cnt, w_cnt_next;
    logic                  r_done, w_done_next;
    logic [FILTER_LEN-1:0] r_filt;
    logic                  r_f_ps2c, w_f_next;
    logic                  r_fall;
    logic                  r_c_low, r_d_low;
`ifdef PS2_ACK_CHECK_EN
    logic [1:0]            r_d_sync;
    logic                  r_ack_err, w_ack_next;
`endif

    // open-drain pins: only ever pull low or release
    assign ps2c         = r_c_low ? 1'b0 : 1'bz;
    assign ps2d         = r_d_low ? 1'b0 : 1'bz;
    assign tx_idle      = (r_state == S_IDLE);
    assign tx_done_tick = r_done;
`ifdef PS2_ACK_CHECK_EN
    assign ack_err      = r_ack_err;
`else
    assign ack_err      = 1'b0;
`endif

    // filtered clock level: change only on a unanimous sample window
    always_comb begin
        w_f_next = r_f_ps2c;
        if (&r_filt) begin
            w_f_next = 1'b1;
        end else if (~|r_filt) begin
            w_f_next = 1'b0;
        end else begin
            w_f_next = r_f_ps2c;
        end
    end

    // ps2c glitch filter and registered falling-edge pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_filt   <= '1;
            r_f_ps2c <= 1'b1;
            r_fall   <= 1'b0;
        end else begin
            r_filt   <= {r_filt[FILTER_LEN-2:0], ps2c};
            r_f_ps2c <= w_f_next;
            r_fall   <= r_f_ps2c & ~w_f_next;
        end
    end

`ifdef PS2_ACK_CHECK_EN
    // two-flop synchroniser for the device-driven data line
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_d_sync <= 2'b11;
        end else begin
            r_d_sync <= {r_d_sync[0], ps2d};
        end
    end
`endif

    // next-state and datapath updates
    always_comb begin
        w_state_next = r_state;
        w_b_next     = r_b;
        w_n_next     = r_n;
        w_cnt_next   = r_cnt;
        w_done_next  = 1'b0;
`ifdef PS2_ACK_CHECK_EN
        w_ack_next   = r_ack_err;
`endif
        case (r_state)
            S_IDLE: begin
                if (wr_ps2) begin
                    w_b_next     = {odd_parity(din), din};
                    w_n_next     = 4'd8;
                    w_cnt_next   = '0;
                    w_state_next = S_RTS;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_RTS: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_next   = '0;
                    w_state_next = S_START;
                end else begin
                    w_cnt_next   = r_cnt + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            S_START: begin
                if (r_fall) begin
                    w_state_next = S_DATA;
                end else begin
                    w_state_next = S_START;
                end
            end
            S_DATA: begin
                if (r_fall) begin
                    w_b_next = {1'b0, r_b[8:1]};
                    if (r_n == 4'd0) begin
                        w_state_next = S_STOP;
                    end else begin
                        w_n_next = r_n - 4'd1;
                    end
                end else begin
                    w_state_next = S_DATA;
                end
            end
            S_STOP: begin
                if (r_fall) begin
                    w_state_next = S_ACK;
                end else begin
                    w_state_next = S_STOP;
                end
            end
            S_ACK: begin
                // the done pulse is issued while still in ack, so that cycle counts as busy
                if (r_done) begin
                    w_state_next = S_IDLE;
                end else if (r_fall) begin
                    w_done_next = 1'b1;
`ifdef PS2_ACK_CHECK_EN
                    w_ack_next  = r_d_sync[1];
`endif
                end else begin
                    w_state_next = S_ACK;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // state, datapath and line-drive registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_b       <= 9'd0;
            r_n       <= 4'd0;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_c_low   <= 1'b0;
            r_d_low   <= 1'b0;
`ifdef PS2_ACK_CHECK_EN
            r_ack_err <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_next;
            r_b       <= w_b_next;
            r_n       <= w_n_next;
            r_cnt     <= w_cnt_next;
            r_done    <= w_done_next;
            r_c_low   <= (r_state == S_RTS);
            r_d_low   <= (r_state == S_START) || ((r_state == S_DATA) && !r_b[0]);
`ifdef PS2_ACK_CHECK_EN
            r_ack_err <= w_ack_next;
`endif
        end
    end

endmodule
